// File: rtl/spi_mic_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_mic_receiver
// Purpose  : SPI master for a PmodMIC / ADCS7476-style ADC. Runs a periodic
//            frame, shifts MISO in MSB-first on sCLK rising edges and
//            returns the low DATA_BITS of each frame with a one-cycle
//            SampleValid pulse.
// Revision : 1.0  initial release
// ============================================================================
module spi_mic_receiver #(
  parameter int HALF_PERIOD   = 20,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_BITS     = 12,
  parameter int SAMPLE_PERIOD = 2268
) (
  input  logic                 SystemClock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 MISO,
  output logic                 nSS,
  output logic                 sCLK,
  output logic [DATA_BITS-1:0] Sample,
  output logic                 SampleValid,
  output logic                 FrameErr,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int c_RATE_W = $clog2(SAMPLE_PERIOD);
  localparam int c_HALF_W = $clog2(HALF_PERIOD + 1);
  localparam int c_BIT_W  = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [c_RATE_W-1:0]     r_rateCnt;
  logic [c_HALF_W-1:0]     r_halfCnt;
  logic [c_BIT_W-1:0]      r_bitCnt;
  logic [FRAME_BITS-1:0]   r_shReg;
  logic [DATA_BITS-1:0]    r_sample;
  logic                    r_sampleValid;
  logic                    r_frameErr;
  logic                    r_overrun;

  logic                    w_trigger;
  logic                    w_halfLast;
  logic                    w_firstHigh;
  logic [c_BIT_W-1:0]      w_bitCntNext;
  logic [FRAME_BITS-1:0]   w_shNext;
  logic                    w_nss;
  logic                    w_sclk;

  // Periodic trigger source; only advances while conversions are enabled
  assign w_trigger = Enable && (r_rateCnt == c_RATE_W'(SAMPLE_PERIOD - 1));

  // Frame-timing helpers. The shift happens in the first HIGH cycle, so the
  // "next" views let the last HIGH cycle see the updated bit and data even
  // when HALF_PERIOD is 1.
  assign w_halfLast   = (r_halfCnt == c_HALF_W'(HALF_PERIOD - 1));
  assign w_firstHigh  = (r_state == HIGH) && (r_halfCnt == '0);
  assign w_bitCntNext = w_firstHigh ? (r_bitCnt + c_BIT_W'(1)) : r_bitCnt;
  assign w_shNext     = w_firstHigh ? {r_shReg[FRAME_BITS-2:0], MISO} : r_shReg;

  // Sample-rate counter: wraps at SAMPLE_PERIOD, parked at zero when disabled
  always_ff @(posedge SystemClock) begin
    if (Reset || !Enable) begin
      r_rateCnt <= '0;
    end else if (r_rateCnt == c_RATE_W'(SAMPLE_PERIOD - 1)) begin
      r_rateCnt <= '0;
    end else begin
      r_rateCnt <= r_rateCnt + c_RATE_W'(1);
    end
  end

  // State register
  always_ff @(posedge SystemClock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and pin decode; chip select and clock are pure state decodes
  always_comb begin
    w_stateNext = r_state;
    w_nss       = 1'b1;
    w_sclk      = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_trigger) w_stateNext = SETUP;
      end
      SETUP: begin
        w_nss = 1'b0;
        if (w_halfLast) w_stateNext = LOW;
      end
      LOW: begin
        w_nss  = 1'b0;
        w_sclk = 1'b0;
        if (w_halfLast) w_stateNext = HIGH;
      end
      HIGH: begin
        w_nss = 1'b0;
        if (w_halfLast) begin
          w_stateNext = (w_bitCntNext == c_BIT_W'(FRAME_BITS)) ? DONE : LOW;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Half-period timer restarts on every state change
  always_ff @(posedge SystemClock) begin
    if (Reset) begin
      r_halfCnt <= '0;
    end else if (w_stateNext != r_state) begin
      r_halfCnt <= '0;
    end else if (r_state == SETUP || r_state == LOW || r_state == HIGH) begin
      r_halfCnt <= r_halfCnt + c_HALF_W'(1);
    end
  end

  // Shift register and bit counter; MISO is captured once per sCLK rise
  always_ff @(posedge SystemClock) begin
    if (Reset) begin
      r_shReg  <= '0;
      r_bitCnt <= '0;
    end else begin
      r_shReg <= w_shNext;
      if (r_state == IDLE) begin
        r_bitCnt <= '0;
      end else begin
        r_bitCnt <= w_bitCntNext;
      end
    end
  end

  // Result registers load on entry to DONE so Sample is already valid
  // during the SampleValid cycle
  always_ff @(posedge SystemClock) begin
    if (Reset) begin
      r_sample      <= '0;
      r_frameErr    <= 1'b0;
      r_sampleValid <= 1'b0;
    end else begin
      r_sampleValid <= (r_state == HIGH) && (w_stateNext == DONE);
      if ((r_state == HIGH) && (w_stateNext == DONE)) begin
        r_sample   <= w_shNext[DATA_BITS-1:0];
        r_frameErr <= |w_shNext[FRAME_BITS-1:DATA_BITS];
      end
    end
  end

  // Sticky flag: a trigger arrived while a frame was still running
  always_ff @(posedge SystemClock) begin
    if (Reset) begin
      r_overrun <= 1'b0;
    end else if (w_trigger && (r_state != IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign nSS         = w_nss;
  assign sCLK        = w_sclk;
  assign Sample      = r_sample;
  assign SampleValid = r_sampleValid;
  assign FrameErr    = r_frameErr;
  assign Overrun     = r_overrun;
  assign Busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_mic_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mic_receiver
// Purpose  : Scoreboard bench for spi_mic_receiver. An ADC model serves
//            queued frame words on sCLK falls; a monitor pops expected
//            samples on SampleValid and checks frame timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_mic_receiver;

  logic        clk = 1'b0;
  logic        rst0, rst1, en0, en1, miso0, miso1;
  logic        nss0, sclk0, sv0, ferr0, ovr0, busy0;
  logic        nss1, sclk1, sv1, ferr1, ovr1, busy1;
  logic [11:0] sample0, sample1;

  typedef struct packed {
    logic [11:0] s;
    logic        e;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] wordQ[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int validCnt0 = 0;
  int validCnt1 = 0;
  int riseCnt = 0;
  int nssFallCyc = 0;
  int lastRiseCyc = 0;
  int lastStartCyc = 0;
  int enRiseCyc = 0;
  bit startValid = 0;
  bit enRiseValid = 0;
  bit start1 = 0;
  bit done1 = 0;

  always #5 clk = ~clk;

  spi_mic_receiver dut0 (
    .SystemClock(clk), .Reset(rst0), .Enable(en0), .MISO(miso0),
    .nSS(nss0), .sCLK(sclk0), .Sample(sample0), .SampleValid(sv0),
    .FrameErr(ferr0), .Overrun(ovr0), .Busy(busy0)
  );

  spi_mic_receiver #(.SAMPLE_PERIOD(500)) dut1 (
    .SystemClock(clk), .Reset(rst1), .Enable(en1), .MISO(miso1),
    .nSS(nss1), .sCLK(sclk1), .Sample(sample1), .SampleValid(sv1),
    .FrameErr(ferr1), .Overrun(ovr1), .Busy(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic queueFrame(input logic [15:0] w, input bit expectOut);
    exp_t e;
    wordQ.push_back(w);
    if (expectOut) begin
      e.s = w[11:0];
      e.e = |w[15:12];
      expQ.push_back(e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitValid(input int target, input int budget);
    int n = 0;
    while (validCnt0 < target && n < budget) begin
      cycles(1);
      n++;
    end
    chk("wait_valid_timeout", (validCnt0 >= target) ? 1 : 0, 1);
  endtask

  // ADC model, frame-timing monitor and scoreboard for dut0
  logic        prevNss = 1'b1, prevSclk = 1'b1, prevEn = 1'b0;
  logic [15:0] curWord = '0;
  int          bitIdx = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst0 || !en0) begin
      startValid  = 0;
      enRiseValid = 0;
    end
    if (!prevEn && en0 && !rst0) begin
      enRiseValid = 1;
      enRiseCyc   = cyc;
    end
    if (prevNss && !nss0) begin
      curWord = (wordQ.size() > 0) ? wordQ.pop_front() : 16'h0000;
      bitIdx  = 0;
      riseCnt = 0;
      if (startValid) chk("frame_spacing", cyc - lastStartCyc, 2268);
      else if (enRiseValid) chk("enable_to_frame", cyc - enRiseCyc, 2268);
      startValid   = 1;
      enRiseValid  = 0;
      lastStartCyc = cyc;
      nssFallCyc   = cyc;
    end
    if (prevSclk != sclk0 && nss0) chk("sclk_idle_toggle", 1, 0);
    if (prevSclk && !sclk0 && !nss0) begin
      if (riseCnt == 0) chk("nss_to_first_fall", cyc - nssFallCyc, 20);
      miso0 = (bitIdx < 16) ? curWord[15 - bitIdx] : 1'b0;
      bitIdx++;
    end
    if (!prevSclk && sclk0 && !nss0) begin
      if (riseCnt > 0) chk("rise_period", cyc - lastRiseCyc, 40);
      riseCnt++;
      lastRiseCyc = cyc;
    end
    if (sv0) begin
      validCnt0++;
      chk("rise_count", riseCnt, 16);
      chk("last_rise_to_valid", cyc - lastRiseCyc, 20);
      chk("nss_high_in_done", nss0, 1);
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got sample %0h, none expected", sample0);
      end else begin
        e = expQ.pop_front();
        chk("sample", sample0, e.s);
        chk("frame_err", ferr0, e.e);
      end
    end
    prevNss  = nss0;
    prevSclk = sclk0;
    prevEn   = en0;
  end

  // Monitor for the short-period instance: frames stay clean under overrun
  always @(negedge clk) begin
    if (sv1) begin
      validCnt1++;
      chk("ovr_sample", sample1, 12'h000);
      chk("ovr_frame_err", ferr1, 0);
      chk("ovr_nss_done", nss1, 1);
    end
  end

  // Short-period instance sequence
  initial begin
    wait (start1);
    cycles(1);
    en1 = 1'b1;
    cycles(900);
    chk("overrun_before", ovr1, 0);
    cycles(4100);
    chk("overrun_frames", validCnt1, 4);
    chk("overrun_set", ovr1, 1);
    cycles(2000);
    chk("overrun_sticky", ovr1, 1);
    done1 = 1;
  end

  initial begin
    int act;
    int n;
    rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
    miso0 = 1'b0; miso1 = 1'b0;
    cycles(4);
    chk("rst_nss", nss0, 1);
    chk("rst_sclk", sclk0, 1);
    chk("rst_sample", sample0, 12'h000);
    chk("rst_valid", sv0, 0);
    chk("rst_ferr", ferr0, 0);
    chk("rst_overrun", ovr0, 0);
    chk("rst_busy", busy0, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    start1 = 1;

    // Back-to-back frames at the nominal rate
    queueFrame(16'h0B22, 1);
    queueFrame(16'hEB22, 1);
    queueFrame(16'h0FFF, 1);
    queueFrame(16'h8001, 1);
    en0 = 1'b1;
    waitValid(4, 12000);

    // Long disable: bus stays idle, last sample held
    en0 = 1'b0;
    act = 0;
    repeat (10000) begin
      cycles(1);
      if (nss0 !== 1'b1 || sclk0 !== 1'b1 || sv0 !== 1'b0) act = 1;
    end
    chk("disabled_quiet", act, 0);
    chk("disabled_no_valid", validCnt0, 4);
    chk("sample_held", sample0, 12'h001);
    chk("ferr_held", ferr0, 1);

    // Enable dropped mid-frame: frame completes, nothing follows
    queueFrame(16'h0A5C, 1);
    en0 = 1'b1;
    n = 0;
    while (!busy0 && n < 3000) begin cycles(1); n++; end
    chk("busy_timeout", busy0, 1);
    cycles(100);
    en0 = 1'b0;
    waitValid(5, 1000);
    act = 0;
    repeat (3000) begin
      cycles(1);
      if (busy0 !== 1'b0) act = 1;
    end
    chk("no_frame_after_disable", act, 0);

    // Reset in the middle of a frame
    queueFrame(16'h0777, 0);
    en0 = 1'b1;
    n = 0;
    while (!(busy0 && riseCnt == 8) && n < 3000) begin cycles(1); n++; end
    chk("rise8_timeout", riseCnt, 8);
    rst0 = 1'b1;
    en0  = 1'b0;
    cycles(1);
    chk("abort_nss", nss0, 1);
    chk("abort_sclk", sclk0, 1);
    chk("abort_valid", sv0, 0);
    chk("abort_busy", busy0, 0);
    cycles(1);
    rst0 = 1'b0;
    cycles(3000);
    chk("abort_no_valid", validCnt0, 5);
    chk("overrun_nominal", ovr0, 0);
    chk("scoreboard_drained", expQ.size(), 0);

    n = 0;
    while (!done1 && n < 20000) begin cycles(1); n++; end
    chk("short_period_done", done1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
